// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
// Contents:
//   XLEN_DEFAULT  default operand / HI / LO width
//   OP_*          operation encodings on the 3-bit op port
//   state_e       sequencer states
//   op_is_*       decode helpers for the arithmetic ops (0..3)
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] OP_MULTU = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_DIVU  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } state_e;

  // Ops 0..3 go through the iterative datapath.
  function automatic logic op_is_arith(input logic [2:0] op);
    return op <= OP_DIV;
  endfunction

  // Bit 1 of the encoding separates divide from multiply.
  function automatic logic op_is_div(input logic [2:0] op);
    return op[1];
  endfunction

  // Bit 0 of the encoding marks the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared multiply/divide datapath (combinational).
// Ports:
//   is_div    1: restoring shift-subtract step, 0: shift-add step
//   acc       upper working register (partial product / partial remainder)
//   q         lower working register (multiplier / dividend-quotient)
//   m         multiplicand or divisor magnitude
//   acc_next  next value of acc
//   q_next    next value of q; in divide mode the LSB is left 0 and the
//             caller fills in the quotient bit from borrow
//   borrow    divide mode: 1 when the trial subtraction went negative
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] q_next,
  output logic            borrow
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    shifted = {acc, q[XLEN-1]};
    // The partial remainder stays below m, so shifted < 2*m and an
    // XLEN+1-bit subtraction is enough: its MSB is exactly the borrow.
    diff    = shifted - {1'b0, m};
    borrow  = diff[XLEN];

    if (is_div) begin
      acc_next = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      q_next   = {q[XLEN-2:0], 1'b0};
    end else begin
      acc_next = sum[XLEN:1];
      q_next   = {sum[0], q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair, with
// single-cycle MTHI/MTLO writes.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   start/op  op request (0 MULTU,1 MULT,2 DIVU,3 DIV,4 MTHI,5 MTLO)
//   a, b      rs / rt operands
//   flush     abort any in-flight op
//   busy      op in flight (PREP/RUN)
//   done      one-cycle pulse while HI/LO show a fresh result
//   dbz       sticky divide-by-zero flag
//   hi, lo    architectural HI/LO
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            dbz,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_e            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [XLEN-1:0]   a_reg, b_reg, m_reg, acc_reg, q_reg;
  logic [XLEN-1:0]   hi_reg, lo_reg;
  logic              is_div_reg, is_signed_reg, res_neg_reg, rem_neg_reg;
  logic              div0_reg, dbz_reg, mt_done_reg;

  logic              accept;
  logic              b_zero;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic [XLEN-1:0]   step_acc, step_q;
  logic              step_borrow;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   fix_hi, fix_lo;
  logic              fix_commit;

  // flush in the same cycle as start drops the request.
  assign accept = (state_reg == IDLE) && start && !flush;
  assign b_zero = (b_reg == '0);
  assign a_abs  = (is_signed_reg && a_reg[XLEN-1]) ? -a_reg : a_reg;
  assign b_abs  = (is_signed_reg && b_reg[XLEN-1]) ? -b_reg : b_reg;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div   (is_div_reg),
    .acc      (acc_reg),
    .q        (q_reg),
    .m        (m_reg),
    .acc_next (step_acc),
    .q_next   (step_q),
    .borrow   (step_borrow)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept && op_is_arith(op)) state_next = PREP;
      PREP:    state_next = (is_div_reg && b_zero) ? FIX : RUN;
      RUN:     if (cnt_reg == CNT_W'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Sign correction of the raw magnitude result, shown during FIX.
  always_comb begin
    prod     = {acc_reg, q_reg};
    prod_fix = res_neg_reg ? -prod : prod;
    fix_hi   = prod_fix[2*XLEN-1:XLEN];
    fix_lo   = prod_fix[XLEN-1:0];
    if (div0_reg) begin
      fix_hi = a_reg;
      fix_lo = '1;
    end else if (is_div_reg) begin
      fix_lo = res_neg_reg ? -q_reg : q_reg;
      fix_hi = rem_neg_reg ? -acc_reg : acc_reg;
    end
  end

  // A flush landing on FIX abandons the result, so done and the HI/LO
  // bypass are gated with it.
  assign fix_commit = (state_reg == FIX) && !flush;
  assign busy       = (state_reg == PREP) || (state_reg == RUN);
  assign done       = fix_commit || mt_done_reg;
  assign dbz        = dbz_reg;
  assign hi         = fix_commit ? fix_hi : hi_reg;
  assign lo         = fix_commit ? fix_lo : lo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      m_reg         <= '0;
      acc_reg       <= '0;
      q_reg         <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      is_div_reg    <= 1'b0;
      is_signed_reg <= 1'b0;
      res_neg_reg   <= 1'b0;
      rem_neg_reg   <= 1'b0;
      div0_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
      mt_done_reg   <= 1'b0;
    end else begin
      mt_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (op == OP_MTHI) begin
              hi_reg      <= a;
              mt_done_reg <= 1'b1;
            end else if (op == OP_MTLO) begin
              lo_reg      <= a;
              mt_done_reg <= 1'b1;
            end else if (op_is_arith(op)) begin
              a_reg         <= a;
              b_reg         <= b;
              is_div_reg    <= op_is_div(op);
              is_signed_reg <= op_is_signed(op);
              dbz_reg       <= 1'b0;
            end
          end
        end
        PREP: begin
          if (!flush) begin
            // Divide: q holds the dividend and shifts out MSB-first.
            // Multiply: q holds the multiplier and shifts out LSB-first.
            m_reg       <= is_div_reg ? b_abs : a_abs;
            q_reg       <= is_div_reg ? a_abs : b_abs;
            acc_reg     <= '0;
            cnt_reg     <= CNT_W'(XLEN);
            res_neg_reg <= is_signed_reg && (a_reg[XLEN-1] ^ b_reg[XLEN-1]);
            rem_neg_reg <= is_signed_reg && a_reg[XLEN-1];
            div0_reg    <= is_div_reg && b_zero;
            if (is_div_reg && b_zero) dbz_reg <= 1'b1;
          end
        end
        RUN: begin
          if (!flush) begin
            acc_reg <= step_acc;
            q_reg   <= is_div_reg ? {step_q[XLEN-1:1], ~step_borrow} : step_q;
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        FIX: begin
          if (!flush) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed scenarios plus random ops,
// expected results from plain integer arithmetic pushed into a scoreboard
// and popped by a monitor whenever done pulses.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [2:0]      op = 3'd0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            busy, done, dbz;
  logic [XLEN-1:0] hi, lo;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          due;
    logic [2:0]  op;
  } exp_t;

  exp_t sb[$];

  // Architectural state as the reference model sees it.
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic        dbz_m = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: results straight from integer arithmetic.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          output exp_t e);
    logic [63:0] p;
    longint      sx, sy;
    int          lat;
    lat = XLEN + 2;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    case (o)
      OP_MULTU: begin
        p = {32'd0, x} * {32'd0, y};
        hi_m = p[63:32]; lo_m = p[31:0]; dbz_m = 1'b0;
      end
      OP_MULT: begin
        p = sx * sy;
        hi_m = p[63:32]; lo_m = p[31:0]; dbz_m = 1'b0;
      end
      OP_DIVU, OP_DIV: begin
        dbz_m = 1'b0;
        if (y == 32'd0) begin
          lo_m = '1; hi_m = x; dbz_m = 1'b1; lat = 2;
        end else if (o == OP_DIVU) begin
          lo_m = x / y; hi_m = x % y;
        end else begin
          p = sx / sy; lo_m = p[31:0];
          p = sx % sy; hi_m = p[31:0];
        end
      end
      OP_MTHI: begin hi_m = x; lat = 1; end
      default: begin lo_m = x; lat = 1; end
    endcase
    e.hi  = hi_m;
    e.lo  = lo_m;
    e.dbz = dbz_m;
    e.due = cyc + lat;
    e.op  = o;
  endtask

  // Issue an op from IDLE; with expect_done the model result is queued.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit expect_done);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    if (expect_done) begin
      model_op(o, x, y, e);
      sb.push_back(e);
    end else if (op_is_arith(o)) begin
      dbz_m = 1'b0;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (k < 80 && (busy || sb.size() != 0)) begin
      @(negedge clk);
      k++;
    end
    n_assert++;
    if (k >= 80) begin
      n_fail++;
      $display("FAIL wait_idle: busy=%0b pending=%0d after 80 cycles, required idle", busy, sb.size());
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL spurious_done: done=1 with no pending op, required done=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        $display("txn op=%0d hi=%h lo=%h dbz=%0b cycle=%0d", e.op, hi, lo, dbz, cyc);
        chk("hi", hi, e.hi);
        chk("lo", lo, e.lo);
        chk("dbz", dbz, e.dbz);
        chk("done_cycle", cyc, e.due);
        chk("busy_at_done", busy, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int c0;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    rst = 1'b0;

    // Full-width unsigned product and busy window.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    nb = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("multu_busy_cycles", nb, XLEN + 1);
    wait_idle();

    issue(OP_MULT, 32'hFFFF_FFF9, 32'd3, 1);       wait_idle();
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1);        wait_idle();
    issue(OP_DIVU, 32'd100, 32'd7, 1);             wait_idle();
    issue(OP_DIVU, 32'h0000_1234, 32'd0, 1);       wait_idle();
    chk("dbz_sticky", dbz, 1);

    // MTHI/MTLO complete in one cycle without busy; dbz stays set.
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1);
    @(negedge clk);
    chk("mthi_busy", busy, 0);
    wait_idle();
    issue(OP_MTLO, 32'h0000_0001, 32'd0, 1);
    @(negedge clk);
    chk("mtlo_busy", busy, 0);
    wait_idle();

    // MULT flushed mid-run: no done, HI/LO untouched, dbz cleared by the start.
    issue(OP_MULT, 32'h0000_1111, 32'h0000_2222, 0);
    @(negedge clk);
    chk("dbz_cleared_on_start", dbz, 0);
    repeat (9) @(negedge clk);
    chk("busy_before_flush", busy, 1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_done", done, 0);
    chk("flush_hi", hi, hi_m);
    chk("flush_lo", lo, lo_m);
    repeat (40) @(negedge clk);

    // Second start during busy is ignored.
    issue(OP_MULTU, 32'd6, 32'd7, 1);
    repeat (5) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd2; b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_idle();

    // Reserved op and flush-with-start are both dropped.
    @(negedge clk);
    start = 1'b1; op = 3'd6; a = 32'h1234_5678; b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("reserved_busy", busy, 0);
    chk("reserved_hi", hi, hi_m);
    chk("reserved_lo", lo, lo_m);
    start = 1'b1; flush = 1'b1; op = OP_MULTU; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("flush_start_busy", busy, 0);
    repeat (40) @(negedge clk);

    // Reset in the middle of a DIV.
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    hi_m = '0; lo_m = '0; dbz_m = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_dbz", dbz, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    repeat (40) @(negedge clk);

    // Random mix of all ops.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 255));
        default: ;
      endcase
      issue(ro, ra, rb, 1);
      wait_idle();
    end

    c0 = sb.size();
    chk("scoreboard_empty", c0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
